// File: rtl/iir_coeff_bank_if.sv
// Host write/commit, filter read and status signals of the IIR coefficient bank.
// The slave modport is the coefficient bank; the master is the host/sequencer side.
interface iir_coeff_bank_if #(
  parameter int COEFF_W = 24,
  parameter int NUM_SEC = 4
);
  localparam int NUM_COEF = NUM_SEC * 5;
  localparam int ADDR_W   = $clog2(NUM_COEF);
  localparam int SEC_W    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;

  logic               wr_valid;
  logic               wr_ready;
  logic [ADDR_W-1:0]  wr_addr;
  logic [COEFF_W-1:0] wr_data;
  logic               wr_commit;
  logic               addr_err;
  logic               stab_err;
  logic [SEC_W-1:0]   err_sec;
  logic               sample_start;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [COEFF_W-1:0] rd_data;
  logic               rd_valid;
  logic               bank_sel;
  logic               swap_done;
  logic               busy;

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_commit, sample_start, rd_en, rd_addr,
    output wr_ready, addr_err, stab_err, err_sec, rd_data, rd_valid, bank_sel,
           swap_done, busy
  );

  modport master (
    output wr_valid, wr_addr, wr_data, wr_commit, sample_start, rd_en, rd_addr,
    input  wr_ready, addr_err, stab_err, err_sec, rd_data, rd_valid, bank_sel,
           swap_done, busy
  );
endinterface

// File: rtl/iir_coeff_bank.sv
// Double-buffered biquad coefficient store: host fills the shadow bank, a commit
// stability-checks it and the banks swap on the next sample boundary.
module iir_coeff_bank #(
  parameter int COEFF_W = 24,
  parameter int FRAC_W  = 22,
  parameter int NUM_SEC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  iir_coeff_bank_if.slave   bus
);
  localparam int NUM_COEF = NUM_SEC * 5;
  localparam int ADDR_W   = $clog2(NUM_COEF);
  localparam int SEC_W    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam int EXT_W    = COEFF_W + 2;

  localparam logic [COEFF_W-1:0]      B0_ONE  = COEFF_W'(1) << FRAC_W;
  localparam logic signed [EXT_W-1:0] ONE_X   = EXT_W'(1) << FRAC_W;
  localparam logic [ADDR_W:0]         N_COEF  = (ADDR_W+1)'(NUM_COEF);
  localparam logic [SEC_W-1:0]        LAST_SEC = SEC_W'(NUM_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ARMED, S_SYNC} state_t;

  state_t             state_q;
  logic [COEFF_W-1:0] bank_q [0:1][0:NUM_COEF-1];
  logic               bank_sel_q;
  logic [SEC_W-1:0]   sec_q;
  logic               wr_ready_q;
  logic               busy_q;
  logic               addr_err_q;
  logic               stab_err_q;
  logic [SEC_W-1:0]   err_sec_q;
  logic               swap_done_q;
  logic [COEFF_W-1:0] rd_data_q;
  logic               rd_valid_q;

  logic [ADDR_W-1:0]      a1_idx_s;
  logic [ADDR_W-1:0]      a2_idx_s;
  logic signed [EXT_W-1:0] a1_x_s;
  logic signed [EXT_W-1:0] a2_x_s;
  logic signed [EXT_W-1:0] a1_abs_s;
  logic signed [EXT_W-1:0] a2_abs_s;
  logic                   sec_ok_s;
  logic                   wr_in_range_s;
  logic                   rd_in_range_s;

  // Stability test of the shadow section under check, widened so |a| and 1+a2 cannot overflow
  always_comb begin
    a1_idx_s = ADDR_W'(32'(sec_q) * 32'd5 + 32'd3);
    a2_idx_s = ADDR_W'(32'(sec_q) * 32'd5 + 32'd4);
    a1_x_s   = {{2{bank_q[~bank_sel_q][a1_idx_s][COEFF_W-1]}}, bank_q[~bank_sel_q][a1_idx_s]};
    a2_x_s   = {{2{bank_q[~bank_sel_q][a2_idx_s][COEFF_W-1]}}, bank_q[~bank_sel_q][a2_idx_s]};
    if (a1_x_s < 0) begin
      a1_abs_s = -a1_x_s;
    end else begin
      a1_abs_s = a1_x_s;
    end
    if (a2_x_s < 0) begin
      a2_abs_s = -a2_x_s;
    end else begin
      a2_abs_s = a2_x_s;
    end
    sec_ok_s      = (a2_abs_s < ONE_X) && (a1_abs_s < (ONE_X + a2_x_s));
    wr_in_range_s = ({1'b0, bus.wr_addr} < N_COEF);
    rd_in_range_s = ({1'b0, bus.rd_addr} < N_COEF);
  end

  // Storage, read port and commit/check/swap sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_COEF; i++) begin
          bank_q[b][i] <= ((i % 5) == 0) ? B0_ONE : '0;
        end
      end
      state_q     <= S_IDLE;
      bank_sel_q  <= 1'b0;
      sec_q       <= '0;
      wr_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      stab_err_q  <= 1'b0;
      err_sec_q   <= '0;
      swap_done_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      addr_err_q  <= 1'b0;
      stab_err_q  <= 1'b0;
      swap_done_q <= 1'b0;

      if (bus.rd_en) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= rd_in_range_s ? bank_q[bank_sel_q][bus.rd_addr] : '0;
      end else begin
        rd_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (bus.wr_valid) begin
            if (wr_in_range_s) begin
              bank_q[~bank_sel_q][bus.wr_addr] <= bus.wr_data;
            end else begin
              addr_err_q <= 1'b1;
            end
          end
          if (bus.wr_commit) begin
            state_q    <= S_CHECK;
            sec_q      <= '0;
            err_sec_q  <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_CHECK: begin
          if (!sec_ok_s) begin
            err_sec_q  <= sec_q;
            stab_err_q <= 1'b1;
            state_q    <= S_IDLE;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (sec_q == LAST_SEC) begin
            state_q <= S_ARMED;
          end else begin
            sec_q <= sec_q + SEC_W'(1);
          end
        end
        S_ARMED: begin
          if (bus.sample_start) begin
            bank_sel_q  <= ~bank_sel_q;
            swap_done_q <= 1'b1;
            state_q     <= S_SYNC;
          end
        end
        S_SYNC: begin
          // Shadow becomes a copy of the new active set so later partial updates start from it
          for (int i = 0; i < NUM_COEF; i++) begin
            bank_q[~bank_sel_q][i] <= bank_q[bank_sel_q][i];
          end
          state_q    <= S_IDLE;
          wr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          wr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wr_ready  = wr_ready_q;
  assign bus.busy      = busy_q;
  assign bus.addr_err  = addr_err_q;
  assign bus.stab_err  = stab_err_q;
  assign bus.err_sec   = err_sec_q;
  assign bus.swap_done = swap_done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.bank_sel  = bank_sel_q;
endmodule

// File: tb/tb_iir_coeff_bank.sv
// Directed bench for iir_coeff_bank: reference copy of both banks, read
// scoreboard queue, and handshake/timing checks around commit and swap.
module tb_iir_coeff_bank;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [23:0] model_act [20];
  logic [23:0] model_sh  [20];
  logic        model_sel = 1'b0;
  logic [23:0] exp_q [$];

  iir_coeff_bank_if #(.COEFF_W(24), .NUM_SEC(4)) bus ();

  iir_coeff_bank #(.COEFF_W(24), .FRAC_W(22), .NUM_SEC(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 20; i++) begin
      model_act[i] = ((i % 5) == 0) ? 24'h400000 : 24'h000000;
      model_sh[i]  = model_act[i];
    end
    model_sel = 1'b0;
  endtask

  task automatic check_read(input int a);
    chk($sformatf("rd_valid[%0d]", a), 32'(bus.rd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      chk($sformatf("rd_data[%0d]", a), 32'(bus.rd_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_read(input int a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 5'(a);
    exp_q.push_back((a < 20) ? model_act[a] : 24'h000000);
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_read(a);
  endtask

  task automatic read_all();
    for (int i = 0; i < 20; i++) do_read(i);
    @(negedge clk);
    chk("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
  endtask

  task automatic wr(input int a, input logic [23:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'(a);
    bus.wr_data  = d;
    @(negedge clk);
    bus.wr_valid = 1'b0;
    chk($sformatf("addr_err[%0d]", a), 32'(bus.addr_err), (a >= 20) ? 32'd1 : 32'd0);
    if (a < 20) model_sh[a] = d;
  endtask

  task automatic commit();
    bus.wr_commit = 1'b1;
    @(negedge clk);
    bus.wr_commit = 1'b0;
  endtask

  task automatic commit_pass();
    commit();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("check_busy[%0d]", k), 32'(bus.busy), 32'd1);
      chk($sformatf("check_no_stab[%0d]", k), 32'(bus.stab_err), 32'd0);
      @(negedge clk);
    end
    chk("armed_busy", 32'(bus.busy), 32'd1);
    chk("armed_wr_ready", 32'(bus.wr_ready), 32'd0);
  endtask

  task automatic commit_reject(input int s);
    commit();
    for (int k = 0; k <= s; k++) begin
      chk($sformatf("rej_wait_stab[%0d]", k), 32'(bus.stab_err), 32'd0);
      chk($sformatf("rej_wait_busy[%0d]", k), 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    chk("stab_err", 32'(bus.stab_err), 32'd1);
    chk("err_sec", 32'(bus.err_sec), 32'(s));
    chk("rej_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rej_busy", 32'(bus.busy), 32'd0);
    chk("rej_bank_sel", 32'(bus.bank_sel), 32'(model_sel));
    @(negedge clk);
    chk("stab_err_pulse", 32'(bus.stab_err), 32'd0);
  endtask

  // From ARMED: read addr 3 in the sample_start cycle (old bank) and the next one (new bank)
  task automatic swap();
    bus.sample_start = 1'b1;
    bus.rd_en        = 1'b1;
    bus.rd_addr      = 5'd3;
    exp_q.push_back(model_act[3]);
    @(negedge clk);
    bus.sample_start = 1'b0;
    check_read(3);
    for (int i = 0; i < 20; i++) model_act[i] = model_sh[i];
    model_sel = ~model_sel;
    exp_q.push_back(model_act[3]);
    chk("swap_done", 32'(bus.swap_done), 32'd1);
    chk("swap_bank_sel", 32'(bus.bank_sel), 32'(model_sel));
    chk("sync_wr_ready", 32'(bus.wr_ready), 32'd0);
    @(negedge clk);
    bus.rd_en = 1'b0;
    check_read(3);
    chk("post_swap_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("swap_done_pulse", 32'(bus.swap_done), 32'd0);
  endtask

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_commit = 1'b0;
    bus.sample_start = 1'b0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    model_reset();
    #12;
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("rst_bank_sel", 32'(bus.bank_sel), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err_sec", 32'(bus.err_sec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    read_all();

    // Full coefficient load, commit, and swap
    for (int s = 0; s < 4; s++) begin
      wr(s*5 + 0, 24'h25EA25);
      wr(s*5 + 1, 24'h4B38E9);
      wr(s*5 + 2, 24'h25EA25);
      wr(s*5 + 3, 24'h32FD14);
      wr(s*5 + 4, 24'h0AD744);
    end
    commit_pass();
    commit();
    chk("armed_commit_ignored", 32'(bus.busy), 32'd1);
    chk("armed_no_stab", 32'(bus.stab_err), 32'd0);
    swap();
    chk("active_a1", 32'(model_act[3]), 32'h32FD14);
    read_all();

    // sample_start in IDLE must not swap
    bus.sample_start = 1'b1;
    @(negedge clk);
    bus.sample_start = 1'b0;
    chk("idle_no_swap", 32'(bus.swap_done), 32'd0);
    chk("idle_bank_sel", 32'(bus.bank_sel), 32'd1);
    @(negedge clk);
    chk("idle_no_swap2", 32'(bus.swap_done), 32'd0);

    // Stability rejects
    wr(14, 24'h400000);
    commit_reject(2);
    read_all();
    wr(14, 24'h0AD744);
    wr(8, 24'h600000);
    wr(9, 24'h100000);
    commit_reject(1);
    wr(8, 24'h32FD14);
    wr(9, 24'h0AD744);

    // Out-of-range write and read
    wr(20, 24'hABCDEF);
    @(negedge clk);
    chk("addr_err_pulse", 32'(bus.addr_err), 32'd0);
    do_read(20);

    // Partial update relies on the shadow copy made after the previous swap
    wr(16, 24'h123456);
    commit_pass();
    swap();
    read_all();

    // Reset while ARMED
    wr(0, 24'h200000);
    commit_pass();
    swap();
    do_read(0);
    wr(1, 24'h111111);
    commit_pass();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_bank_sel", 32'(bus.bank_sel), 32'd0);
    chk("async_rd_data", 32'(bus.rd_data), 32'd0);
    chk("async_wr_ready", 32'(bus.wr_ready), 32'd1);
    chk("async_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.sample_start = 1'b1;
    @(negedge clk);
    bus.sample_start = 1'b0;
    chk("post_rst_no_swap", 32'(bus.swap_done), 32'd0);
    chk("post_rst_bank_sel", 32'(bus.bank_sel), 32'd0);
    read_all();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
